reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised reset controller for SoC top levels. It replaces the fixed 6-bit power-on counter with a staged release of NUM_DOMAINS active-low reset outputs. Release is gated on a filtered PLL lock. After release, the block re-enters reset on PLL lock loss, on a software reset request, or on a watchdog timeout, and records which of these caused the reset. It sits between the PLL and the SoC (CPU, SPI flash controller, peripherals), all on the one CPU clock.

Parameters:
NUM_DOMAINS, 4, number of staged reset outputs; must be >= 1
STAGE_DELAY, 16, cycles between successive domain releases, and before domain 0; must be >= 1
LOCK_FILTER, 8, consecutive pll_lock=1 samples needed before sequencing starts; must be >= 1
WDT_LIMIT, 1000, watchdog count at which a timeout fires; must be >= 1

Ports:
clk  input  1  single clock; all logic on posedge
reset  input  1  synchronous, active-high block reset
pll_lock  input  1  PLL lock indicator (already synchronous to clk)
sw_rst_req  input  1  software reset request, level, sampled only in RUN
wdt_en  input  1  watchdog enable
wdt_kick  input  1  watchdog service pulse; clears the watchdog count
resetn_out  output  NUM_DOMAINS  active-low domain resets; bit 0 released first
ready  output  1  all domains released; high in RUN only
rst_cause  output  2  cause of last reset: 0 POR, 1 LOCK, 2 SW, 3 WDT

Behaviour:
- All outputs are registered. Counter widths use $clog2 of (limit+1).
- On reset=1, at the next edge:
  - state=HOLD, resetn_out=all 0, ready=0, rst_cause=0.
  - lock_cnt, dly_cnt, idx and wdt_cnt are all 0.
- HOLD state:
  - Each edge, lock_cnt increments if pll_lock=1 and clears if pll_lock=0.
  - On the edge that takes the LOCK_FILTER-th consecutive high sample: go to RELEASE, with dly_cnt=0 and idx=0.
  - sw_rst_req, wdt_en and wdt_kick are ignored in HOLD.
- RELEASE state:
  - dly_cnt increments each edge.
  - When dly_cnt==STAGE_DELAY-1: resetn_out[idx] becomes 1, idx increments, dly_cnt becomes 0.
  - On the edge that releases idx==NUM_DOMAINS-1: state becomes RUN and ready becomes 1 on that same edge.
- Release timing: number the first edge that samples pll_lock=1 as edge 1. Domain i then releases on edge LOCK_FILTER+(i+1)*STAGE_DELAY.
- Once released, a domain stays released until the block re-enters HOLD.
- Lock loss in RELEASE: pll_lock=0 → next edge goes to HOLD, resetn_out=all 0, ready=0, rst_cause=1, lock_cnt=0.
- RUN state, exit causes, checked in priority order:
  - pll_lock=0 → HOLD with cause 1.
  - else sw_rst_req=1 → HOLD with cause 2.
  - else watchdog timeout → HOLD with cause 3.
- On any entry to HOLD: resetn_out=all 0, ready=0, lock_cnt=0, wdt_cnt=0, all on the same edge.
- Watchdog, RUN only:
  - wdt_en=0 → wdt_cnt held at 0.
  - wdt_kick=1 → wdt_cnt=0. A kick beats a timeout on the same edge.
  - Otherwise wdt_cnt increments.
  - Timeout fires when wdt_cnt==WDT_LIMIT and wdt_en=1 and wdt_kick=0.
  - wdt_cnt is 0 on entry to RUN.
- rst_cause:
  - Changes only on the edge that enters HOLD from RELEASE or RUN, or on reset.
  - Holds its value through HOLD, RELEASE and RUN.
- reset asserted in any state, including mid-RELEASE: next edge applies the reset values above. rst_cause returns to 0, i.e. the block reset overrides the recorded cause.
- Glitch filtering: a pll_lock glitch during HOLD restarts the lock filter from 0.

Test Plan:
- Defaults; reset for 2 cycles, then pll_lock=1 constant → resetn_out bits rise on edges 24, 40, 56, 72 → resetn_out=4'b1111, ready=1 at edge 72, rst_cause=0.
- pll_lock=1 for 5 cycles, 0 for 1 cycle, then 1 → filter restarts; first release on edge 24 counted from the re-rise.
- Drop pll_lock at edge 45 (domains 0 and 1 released) → next edge resetn_out=0, ready=0, rst_cause=1; after pll_lock returns, full re-sequence with the same 8/16 timing.
- In RUN, sw_rst_req=1 and pll_lock=0 on the same edge → rst_cause=1 (lock has priority). Separately, sw_rst_req=1 alone → rst_cause=2, all domains reset, then re-sequence.
- WDT_LIMIT=100, wdt_en=1:
  - Kick every 50 cycles → no reset for 1000 cycles.
  - Stop kicking → HOLD 101 edges after the last kick, rst_cause=3.
  - Kick on the exact timeout edge → no reset.
- Assert reset mid-RELEASE with rst_cause=3 → next edge: all outputs 0, rst_cause=0, state HOLD; NUM_DOMAINS=1 and STAGE_DELAY=1 config → single release on edge LOCK_FILTER+1.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: staged reset release for an SoC on a single CPU clock.
// A filtered PLL lock starts a timed release of NUM_DOMAINS active-low
// resets, one domain every STAGE_DELAY cycles. Once every domain is out of
// reset the block sits in RUN. It falls back to HOLD on lock loss, on a
// software request or on a watchdog timeout, and records which one caused it.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int STAGE_DELAY = 16,
    parameter int LOCK_FILTER = 8,
    parameter int WDT_LIMIT   = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   pll_lock,
    input  logic                   sw_rst_req,
    input  logic                   wdt_en,
    input  logic                   wdt_kick,
    output logic [NUM_DOMAINS-1:0] resetn_out,
    output logic                   ready,
    output logic [1:0]             rst_cause
);

    // Each counter is sized to hold its own limit value.
    localparam int LOCK_W = $clog2(LOCK_FILTER + 1);
    localparam int DLY_W  = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W  = $clog2(NUM_DOMAINS + 1);
    localparam int WDT_W  = $clog2(WDT_LIMIT + 1);

    // Terminal values the counters are compared against.
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_FILTER - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
    localparam logic [WDT_W-1:0]  WDT_TOP   = WDT_W'(WDT_LIMIT);

    localparam logic [LOCK_W-1:0] LOCK_ZERO = LOCK_W'(1'b0);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1'b1);
    localparam logic [DLY_W-1:0]  DLY_ZERO  = DLY_W'(1'b0);
    localparam logic [DLY_W-1:0]  DLY_ONE   = DLY_W'(1'b1);
    localparam logic [IDX_W-1:0]  IDX_ZERO  = IDX_W'(1'b0);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1'b1);
    localparam logic [WDT_W-1:0]  WDT_ZERO  = WDT_W'(1'b0);
    localparam logic [WDT_W-1:0]  WDT_ONE   = WDT_W'(1'b1);

    localparam logic [NUM_DOMAINS-1:0] ALL_HELD = {NUM_DOMAINS{1'b0}};

    // Reset cause encoding as seen on rst_cause.
    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t                  state_q,    state_d;
    logic [LOCK_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [DLY_W-1:0]        dly_cnt_q,  dly_cnt_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [WDT_W-1:0]        wdt_cnt_q,  wdt_cnt_d;
    logic [NUM_DOMAINS-1:0]  resetn_q,   resetn_d;
    logic                    ready_q,    ready_d;
    logic [1:0]              cause_q,    cause_d;

    logic                    wdt_timeout;
    logic [WDT_W-1:0]        wdt_cnt_run;
    logic                    stage_done;
    logic                    last_stage;
    logic [NUM_DOMAINS-1:0]  release_mask;
    logic                    go_hold;
    logic [1:0]              hold_cause;

    // Watchdog: timeout detection and the count it would take while running.
    always_comb begin
        wdt_timeout = wdt_en && !wdt_kick && (wdt_cnt_q == WDT_TOP);
        if (!wdt_en || wdt_kick) begin
            wdt_cnt_run = WDT_ZERO;
        end else begin
            wdt_cnt_run = wdt_cnt_q + WDT_ONE;
        end
    end

    // Stage bookkeeping: end of the current delay and the domain it frees.
    always_comb begin
        stage_done   = (dly_cnt_q == DLY_LAST);
        last_stage   = (idx_q == IDX_LAST);
        release_mask = ALL_HELD;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                release_mask[i] = 1'b1;
            end else begin
                release_mask[i] = 1'b0;
            end
        end
    end

    // Exit decision out of RELEASE/RUN, lock loss first, then SW, then watchdog.
    always_comb begin
        go_hold    = 1'b0;
        hold_cause = cause_q;
        case (state_q)
            ST_RELEASE: begin
                if (!pll_lock) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else begin
                    go_hold    = 1'b0;
                end
            end
            ST_RUN: begin
                if (!pll_lock) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_LOCK;
                end else if (sw_rst_req) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_SW;
                end else if (wdt_timeout) begin
                    go_hold    = 1'b1;
                    hold_cause = CAUSE_WDT;
                end else begin
                    go_hold    = 1'b0;
                end
            end
            default: begin
                go_hold    = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        dly_cnt_d  = dly_cnt_q;
        idx_d      = idx_q;
        wdt_cnt_d  = wdt_cnt_q;
        resetn_d   = resetn_q;
        ready_d    = ready_q;
        cause_d    = cause_q;

        if (go_hold) begin
            // Every way back into HOLD clears outputs and counters together.
            state_d    = ST_HOLD;
            lock_cnt_d = LOCK_ZERO;
            dly_cnt_d  = DLY_ZERO;
            idx_d      = IDX_ZERO;
            wdt_cnt_d  = WDT_ZERO;
            resetn_d   = ALL_HELD;
            ready_d    = 1'b0;
            cause_d    = hold_cause;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    resetn_d  = ALL_HELD;
                    ready_d   = 1'b0;
                    dly_cnt_d = DLY_ZERO;
                    idx_d     = IDX_ZERO;
                    wdt_cnt_d = WDT_ZERO;
                    if (!pll_lock) begin
                        // Any low sample restarts the filter.
                        lock_cnt_d = LOCK_ZERO;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        state_d    = ST_RELEASE;
                        lock_cnt_d = LOCK_ZERO;
                    end else begin
                        lock_cnt_d = lock_cnt_q + LOCK_ONE;
                    end
                end
                ST_RELEASE: begin
                    if (stage_done) begin
                        dly_cnt_d = DLY_ZERO;
                        resetn_d  = resetn_q | release_mask;
                        if (last_stage) begin
                            state_d   = ST_RUN;
                            ready_d   = 1'b1;
                            idx_d     = IDX_ZERO;
                            wdt_cnt_d = WDT_ZERO;
                        end else begin
                            idx_d     = idx_q + IDX_ONE;
                        end
                    end else begin
                        dly_cnt_d = dly_cnt_q + DLY_ONE;
                    end
                end
                ST_RUN: begin
                    wdt_cnt_d = wdt_cnt_run;
                end
                default: begin
                    // Unreachable encoding: fall back to a fully held reset.
                    state_d    = ST_HOLD;
                    lock_cnt_d = LOCK_ZERO;
                    dly_cnt_d  = DLY_ZERO;
                    idx_d      = IDX_ZERO;
                    wdt_cnt_d  = WDT_ZERO;
                    resetn_d   = ALL_HELD;
                    ready_d    = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous block reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HOLD;
            lock_cnt_q <= LOCK_ZERO;
            dly_cnt_q  <= DLY_ZERO;
            idx_q      <= IDX_ZERO;
            wdt_cnt_q  <= WDT_ZERO;
            resetn_q   <= ALL_HELD;
            ready_q    <= 1'b0;
            cause_q    <= CAUSE_POR;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            dly_cnt_q  <= dly_cnt_d;
            idx_q      <= idx_d;
            wdt_cnt_q  <= wdt_cnt_d;
            resetn_q   <= resetn_d;
            ready_q    <= ready_d;
            cause_q    <= cause_d;
        end
    end

    assign resetn_out = resetn_q;
    assign ready      = ready_q;
    assign rst_cause  = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer: a 4-domain instance (WDT_LIMIT=100) and a
// 1-domain, STAGE_DELAY=1 instance share all inputs. Both are compared every
// cycle against a time-based reference model; the 4-domain instance is also
// checked against a table of hand-derived expectations.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       pll_lock;
    logic       sw_rst_req;
    logic       wdt_en;
    logic       wdt_kick;

    logic [3:0] m_resetn;
    logic       m_ready;
    logic [1:0] m_cause;
    logic [0:0] s_resetn;
    logic       s_ready;
    logic [1:0] s_cause;

    int n_checks = 0;
    int n_errors = 0;

    reset_sequencer #(
        .NUM_DOMAINS(4), .STAGE_DELAY(16), .LOCK_FILTER(8), .WDT_LIMIT(100)
    ) u_main (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
        .wdt_en(wdt_en), .wdt_kick(wdt_kick),
        .resetn_out(m_resetn), .ready(m_ready), .rst_cause(m_cause)
    );

    reset_sequencer #(
        .NUM_DOMAINS(1), .STAGE_DELAY(1), .LOCK_FILTER(8), .WDT_LIMIT(20)
    ) u_small (
        .clk(clk), .reset(reset), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
        .wdt_en(wdt_en), .wdt_kick(wdt_kick),
        .resetn_out(s_resetn), .ready(s_ready), .rst_cause(s_cause)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: mode plus elapsed time; released domains = time / delay.
    localparam int M_HOLD = 0;
    localparam int M_SEQ  = 1;
    localparam int M_RUN  = 2;

    int cfg_nd [2] = '{4, 1};
    int cfg_sd [2] = '{16, 1};
    int cfg_lf [2] = '{8, 8};
    int cfg_wl [2] = '{100, 20};

    int         md_mode  [2];
    int         md_run   [2];   // consecutive lock samples in HOLD
    int         md_t     [2];   // cycles spent sequencing
    int         md_wdt   [2];   // cycles since the watchdog was last cleared
    logic [1:0] md_cause [2];
    bit         md_valid [2] = '{1'b0, 1'b0};

    task automatic model_enter_hold(input int k, input logic [1:0] c);
        md_mode[k]  = M_HOLD;
        md_run[k]   = 0;
        md_wdt[k]   = 0;
        md_cause[k] = c;
    endtask

    task automatic model_step(input int k);
        if (reset) begin
            md_mode[k]  = M_HOLD;
            md_run[k]   = 0;
            md_t[k]     = 0;
            md_wdt[k]   = 0;
            md_cause[k] = 2'd0;
            md_valid[k] = 1'b1;
        end else if (md_mode[k] == M_HOLD) begin
            if (pll_lock) begin
                md_run[k] = md_run[k] + 1;
                if (md_run[k] == cfg_lf[k]) begin
                    md_mode[k] = M_SEQ;
                    md_t[k]    = 0;
                    md_run[k]  = 0;
                end
            end else begin
                md_run[k] = 0;
            end
        end else if (md_mode[k] == M_SEQ) begin
            if (!pll_lock) begin
                model_enter_hold(k, 2'd1);
            end else begin
                md_t[k] = md_t[k] + 1;
                if (md_t[k] / cfg_sd[k] >= cfg_nd[k]) begin
                    md_mode[k] = M_RUN;
                    md_wdt[k]  = 0;
                end
            end
        end else begin
            if (!pll_lock)                                          model_enter_hold(k, 2'd1);
            else if (sw_rst_req)                                    model_enter_hold(k, 2'd2);
            else if (wdt_en && !wdt_kick && md_wdt[k] == cfg_wl[k]) model_enter_hold(k, 2'd3);
            else if (!wdt_en || wdt_kick)                           md_wdt[k] = 0;
            else                                                    md_wdt[k] = md_wdt[k] + 1;
        end
    endtask

    function automatic logic [3:0] model_resetn(input int k);
        int rel;
        if (md_mode[k] == M_HOLD) return 4'b0000;
        rel = (md_mode[k] == M_RUN) ? cfg_nd[k] : md_t[k] / cfg_sd[k];
        if (rel > cfg_nd[k]) rel = cfg_nd[k];
        return 4'((1 << rel) - 1);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic r, input logic l, input logic s, input logic e, input logic k);
        reset      = r;
        pll_lock   = l;
        sw_rst_req = s;
        wdt_en     = e;
        wdt_kick   = k;
    endtask

    // One clock: advance both models on the edge, compare just after it.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        if (md_valid[0]) begin
            check("model_main_resetn", m_resetn, model_resetn(0));
            check("model_main_ready", {3'b000, m_ready}, {3'b000, md_mode[0] == M_RUN});
            check("model_main_cause", {2'b00, m_cause}, {2'b00, md_cause[0]});
        end
        if (md_valid[1]) begin
            check("model_small_resetn", {3'b000, s_resetn}, model_resetn(1));
            check("model_small_ready", {3'b000, s_ready}, {3'b000, md_mode[1] == M_RUN});
            check("model_small_cause", {2'b00, s_cause}, {2'b00, md_cause[1]});
        end
    endtask

    typedef struct {
        int         n;
        logic       rst, lock, sw, en, kick;
        logic [3:0] exp_rn;
        logic       exp_rdy;
        logic [1:0] exp_cause;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int n, input logic r, input logic l, input logic s,
                                input logic e, input logic k, input logic [3:0] rn,
                                input logic rdy, input logic [1:0] c);
        vec_t v;
        v.n = n; v.rst = r; v.lock = l; v.sw = s; v.en = e; v.kick = k;
        v.exp_rn = rn; v.exp_rdy = rdy; v.exp_cause = c;
        tbl.push_back(v);
    endfunction

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        //   n    rst   lock  sw    en    kick  resetn   rdy   cause
        add(2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0); // reset state
        add(23,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0); // edge 23
        add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0); // edge 24
        add(15,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0); // edge 39
        add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd0); // edge 40
        add(16,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0, 2'd0); // edge 56
        add(15,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 1'b0, 2'd0); // edge 71
        add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd0); // edge 72 RUN
        add(1,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2); // sw request
        add(72,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd2); // re-sequence
        add(1,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1); // lock beats sw
        add(5,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1); // filter run
        add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1); // glitch
        add(23,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1); // re-rise 23
        add(1,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd1); // re-rise 24
        add(48,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd1); // re-rise 72
        add(100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd1); // wdt at limit
        add(1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 1'b1, 2'd1); // kick on timeout edge
        add(100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 1'b1, 2'd1);
        add(1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3); // timeout
        add(30,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd3); // mid-RELEASE
        add(1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0); // block reset wins
        add(45,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0, 2'd0); // edge 45
        add(1,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1); // lock loss
        add(72,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, 2'd1); // full re-sequence

        foreach (tbl[i]) begin
            set_in(tbl[i].rst, tbl[i].lock, tbl[i].sw, tbl[i].en, tbl[i].kick);
            for (int c = 0; c < tbl[i].n; c++) tick();
            check($sformatf("vec%0d_resetn", i), m_resetn, tbl[i].exp_rn);
            check($sformatf("vec%0d_ready", i), {3'b000, m_ready}, {3'b000, tbl[i].exp_rdy});
            check($sformatf("vec%0d_cause", i), {2'b00, m_cause}, {2'b00, tbl[i].exp_cause});
        end

        // Kick every 50 cycles for 1000 cycles: RUN must hold throughout.
        for (int g = 0; g < 20; g++) begin
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            for (int c = 0; c < 49; c++) tick();
            set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
            tick();
            check("kick_ready", {3'b000, m_ready}, 4'b0001);
            check("kick_resetn", m_resetn, 4'b1111);
        end
        // Stop kicking: HOLD exactly 101 edges after the last kick.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 100; c++) tick();
        check("nokick_100_ready", {3'b000, m_ready}, 4'b0001);
        tick();
        check("nokick_101_ready", {3'b000, m_ready}, 4'b0000);
        check("nokick_101_resetn", m_resetn, 4'b0000);
        check("nokick_101_cause", {2'b00, m_cause}, 4'd3);

        // Single-domain, STAGE_DELAY=1: release on edge LOCK_FILTER+1.
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 8; c++) tick();
        check("small_edge8_resetn", {3'b000, s_resetn}, 4'b0000);
        check("small_edge8_ready", {3'b000, s_ready}, 4'b0000);
        tick();
        check("small_edge9_resetn", {3'b000, s_resetn}, 4'b0001);
        check("small_edge9_ready", {3'b000, s_ready}, 4'b0001);
        check("small_edge9_cause", {2'b00, s_cause}, 4'd0);
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("small_prio_cause", {2'b00, s_cause}, 4'd1);
        check("small_prio_resetn", {3'b000, s_resetn}, 4'b0000);

        // Randomized traffic checked only against the reference model.
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4000; c++) begin
            reset      = ($urandom_range(0, 499) == 0);
            pll_lock   = ($urandom_range(0, 299) != 0);
            sw_rst_req = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 199) == 0) wdt_en = ~wdt_en;
            wdt_kick   = ($urandom_range(0, 119) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
